// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch/jump resolution, registered result,
// mispredict redirect, perf counters, optional BHT (macro BRANCH_BHT_EN).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (op, op_type, pc, rj, rd, offs,
//                       pred_taken, pred_target)
//   flush               drop held result, refuse input
//   out_valid/out_ready output handshake (out_taken, out_target, out_link,
//                       out_mispredict, out_redirect_pc)
//   lk_pc/lk_taken      fetch-side BHT lookup (0 when BHT not built)
//   branch_cnt          accepted branch/jump ops
//   mispred_cnt         accepted branch/jump ops that mispredicted
module branch_resolve #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      op,
    input  logic [3:0]      op_type,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rj,
    input  logic [XLEN-1:0] rd,
    input  logic [XLEN-1:0] offs,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_link,
    output logic            out_mispredict,
    output logic [XLEN-1:0] out_redirect_pc,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_taken,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam logic [3:0] OP_TYPE_BJ = 4'h3;
    localparam logic [7:0] OP_B       = 8'h50;
    localparam logic [7:0] OP_BL      = 8'h54;
    localparam logic [7:0] OP_JIRL    = 8'h4c;
    localparam logic [7:0] OP_BEQ     = 8'h58;
    localparam logic [7:0] OP_BNE     = 8'h5c;
    localparam logic [7:0] OP_BLT     = 8'h60;
    localparam logic [7:0] OP_BGE     = 8'h64;
    localparam logic [7:0] OP_BLTU    = 8'h68;
    localparam logic [7:0] OP_BGEU    = 8'h6c;

    logic is_bj;
    logic d_b, d_bl, d_jirl;
    logic d_beq, d_bne, d_blt;
    logic d_bge, d_bltu, d_bgeu;
    logic is_cond;
    logic eq, lt_s, lt_u;
    logic taken;
    logic mis;
    logic accept;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] redir;

    assign is_bj  = (op_type == OP_TYPE_BJ);
    assign d_b    = (op == OP_B);
    assign d_bl   = (op == OP_BL);
    assign d_jirl = (op == OP_JIRL);
    assign d_beq  = (op == OP_BEQ);
    assign d_bne  = (op == OP_BNE);
    assign d_blt  = (op == OP_BLT);
    assign d_bge  = (op == OP_BGE);
    assign d_bltu = (op == OP_BLTU);
    assign d_bgeu = (op == OP_BGEU);

    assign is_cond = is_bj
                   & (d_beq | d_bne | d_blt
                   | d_bge | d_bltu | d_bgeu);

    assign eq   = (rj == rd);
    assign lt_s = ($signed(rj) < $signed(rd));
    assign lt_u = (rj < rd);

    always_comb begin
        taken = 1'b0;
        if (is_bj) begin
            unique case (1'b1)
                d_b, d_bl, d_jirl: taken = 1'b1;
                d_beq:             taken = eq;
                d_bne:             taken = !eq;
                d_blt:             taken = lt_s;
                d_bge:             taken = !lt_s;
                d_bltu:            taken = lt_u;
                d_bgeu:            taken = !lt_u;
                default:           taken = 1'b0;
            endcase
        end
    end

    assign pc4    = pc + XLEN'(4);
    assign target = d_jirl ? (rj + offs)
                           : (pc + offs);
    assign link   = (d_bl | d_jirl) ? pc4 : '0;
    assign redir  = taken ? target : pc4;

    // A not-taken prediction never carries a
    // meaningful target, so only compare it
    // when the op actually goes taken.
    assign mis = (taken != pred_taken)
               | (taken & (target != pred_target));

    assign in_ready = !rst && !flush
                    && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_taken       <= 1'b0;
            out_target      <= '0;
            out_link        <= '0;
            out_mispredict  <= 1'b0;
            out_redirect_pc <= '0;
            branch_cnt      <= '0;
            mispred_cnt     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_taken       <= taken;
            out_target      <= target;
            out_link        <= link;
            out_mispredict  <= mis;
            out_redirect_pc <= redir;
            if (is_bj) begin
                branch_cnt <= branch_cnt + 32'd1;
                if (mis) begin
                    mispred_cnt <= mispred_cnt + 32'd1;
                end
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BRANCH_BHT_EN
    localparam int BHT_N = 1 << BHT_IDX_W;

    logic [1:0] bht [BHT_N];
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [BHT_IDX_W-1:0] lk_idx;
    logic unused_lk;

    assign upd_idx = pc[BHT_IDX_W+1:2];
    assign lk_idx  = lk_pc[BHT_IDX_W+1:2];
    assign unused_lk = ^{lk_pc[XLEN-1:BHT_IDX_W+2],
                         lk_pc[1:0]};

    // Registered table: an update lands on the
    // edge, so a lookup of the same index sees
    // it only from the following cycle.
    assign lk_taken = bht[lk_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept && is_cond) begin
            if (taken) begin
                if (bht[upd_idx] != 2'b11) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'b01;
                end
            end else begin
                if (bht[upd_idx] != 2'b00) begin
                    bht[upd_idx] <= bht[upd_idx] - 2'b01;
                end
            end
        end
    end
`else
    logic unused_lk;

    assign unused_lk = ^lk_pc;
    assign lk_taken  = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed vector table plus handshake, flush,
// BHT and counter-wrap sequences for branch_resolve.
module tb_branch_resolve;

    localparam logic [3:0] OP_TYPE_BJ = 4'h3;
    localparam logic [7:0] OP_B       = 8'h50;
    localparam logic [7:0] OP_BL      = 8'h54;
    localparam logic [7:0] OP_JIRL    = 8'h4c;
    localparam logic [7:0] OP_BEQ     = 8'h58;
    localparam logic [7:0] OP_BNE     = 8'h5c;
    localparam logic [7:0] OP_BLT     = 8'h60;
    localparam logic [7:0] OP_BGE     = 8'h64;
    localparam logic [7:0] OP_BLTU    = 8'h68;
    localparam logic [7:0] OP_BGEU    = 8'h6c;

`ifdef BRANCH_BHT_EN
    localparam logic BHT_ON = 1'b1;
`else
    localparam logic BHT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  op;
    logic [3:0]  op_type;
    logic [31:0] pc, rj, rd, offs;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic [31:0] out_link;
    logic        out_mispredict;
    logic [31:0] out_redirect_pc;
    logic [31:0] lk_pc;
    logic        lk_taken;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_resolve #(.XLEN(32), .BHT_IDX_W(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_type(op_type), .pc(pc),
        .rj(rj), .rd(rd), .offs(offs),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target),
        .out_link(out_link),
        .out_mispredict(out_mispredict),
        .out_redirect_pc(out_redirect_pc),
        .lk_pc(lk_pc), .lk_taken(lk_taken),
        .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  ty;
        logic [31:0] pc, rj, rd, offs;
        logic        pt;
        logic [31:0] ptgt;
        logic        et;
        logic [31:0] etgt, elink;
        logic        em;
        logic [31:0] eredir;
    } vec_t;

    vec_t v [11];

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_bc = 0;
    logic [31:0] exp_mc = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] o,
                         input logic [3:0] t,
                         input logic [31:0] p,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] f,
                         input logic pt,
                         input logic [31:0] ptg);
        op = o; op_type = t; pc = p;
        rj = a; rd = b; offs = f;
        pred_taken = pt; pred_target = ptg;
    endtask

    initial begin
        // op ty pc rj rd offs pt ptgt | et etgt elink em eredir
        v[0]  = '{OP_BEQ, OP_TYPE_BJ, 32'h100, 32'h5, 32'h5,
                  32'h20, 1'b0, 32'h0,
                  1'b1, 32'h120, 32'h0, 1'b1, 32'h120};
        v[1]  = '{OP_BLT, OP_TYPE_BJ, 32'h104, 32'hFFFFFFFF,
                  32'h1, 32'h10, 1'b1, 32'h114,
                  1'b1, 32'h114, 32'h0, 1'b0, 32'h114};
        v[2]  = '{OP_BLTU, OP_TYPE_BJ, 32'h108, 32'hFFFFFFFF,
                  32'h1, 32'h10, 1'b1, 32'h118,
                  1'b0, 32'h118, 32'h0, 1'b1, 32'h10c};
        v[3]  = '{OP_JIRL, OP_TYPE_BJ, 32'h200, 32'h1000,
                  32'h0, 32'h8, 1'b1, 32'h1008,
                  1'b1, 32'h1008, 32'h204, 1'b0, 32'h1008};
        v[4]  = '{OP_BL, OP_TYPE_BJ, 32'h300, 32'h0, 32'h0,
                  32'hFFFFFFF0, 1'b1, 32'h2f0,
                  1'b1, 32'h2f0, 32'h304, 1'b0, 32'h2f0};
        v[5]  = '{OP_B, OP_TYPE_BJ, 32'h400, 32'h0, 32'h0,
                  32'h40, 1'b1, 32'h444,
                  1'b1, 32'h440, 32'h0, 1'b1, 32'h440};
        v[6]  = '{OP_BNE, OP_TYPE_BJ, 32'h500, 32'h3, 32'h3,
                  32'h8, 1'b0, 32'h0,
                  1'b0, 32'h508, 32'h0, 1'b0, 32'h504};
        v[7]  = '{OP_BGE, OP_TYPE_BJ, 32'h600, 32'h1,
                  32'hFFFFFFFF, 32'h4, 1'b0, 32'h0,
                  1'b1, 32'h604, 32'h0, 1'b1, 32'h604};
        v[8]  = '{OP_BGEU, OP_TYPE_BJ, 32'h700, 32'h1,
                  32'hFFFFFFFF, 32'h4, 1'b0, 32'h0,
                  1'b0, 32'h704, 32'h0, 1'b0, 32'h704};
        v[9]  = '{OP_BEQ, 4'h0, 32'h800, 32'h9, 32'h9,
                  32'h100, 1'b1, 32'h900,
                  1'b0, 32'h900, 32'h0, 1'b1, 32'h804};
        v[10] = '{8'hFF, OP_TYPE_BJ, 32'h900, 32'h0, 32'h0,
                  32'h10, 1'b0, 32'h0,
                  1'b0, 32'h910, 32'h0, 1'b0, 32'h904};

        rst = 1'b1; flush = 1'b0;
        out_ready = 1'b1; lk_pc = 32'h40;
        in_valid = 1'b1;
        drive(OP_B, OP_TYPE_BJ, 32'h10, 0, 0,
              32'h4, 1'b0, 32'h0);
        step();
        step();
        chk("in_ready_in_reset", {31'b0, in_ready}, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_taken", {31'b0, out_taken}, 0);
        chk("rst_mis", {31'b0, out_mispredict}, 0);
        chk("rst_target", out_target, 0);
        chk("rst_link", out_link, 0);
        chk("rst_redir", out_redirect_pc, 0);
        chk("rst_bcnt", branch_cnt, 0);
        chk("rst_mcnt", mispred_cnt, 0);
        chk("rst_lk", {31'b0, lk_taken}, 0);

        for (int i = 0; i < 11; i++) begin
            drive(v[i].op, v[i].ty, v[i].pc,
                  v[i].rj, v[i].rd, v[i].offs,
                  v[i].pt, v[i].ptgt);
            in_valid = 1'b1;
            step();
            if (v[i].ty == OP_TYPE_BJ) begin
                exp_bc++;
                if (v[i].em) exp_mc++;
            end
            chk($sformatf("v%0d_valid", i),
                {31'b0, out_valid}, 1);
            chk($sformatf("v%0d_taken", i),
                {31'b0, out_taken}, {31'b0, v[i].et});
            chk($sformatf("v%0d_target", i),
                out_target, v[i].etgt);
            chk($sformatf("v%0d_link", i),
                out_link, v[i].elink);
            chk($sformatf("v%0d_mis", i),
                {31'b0, out_mispredict},
                {31'b0, v[i].em});
            chk($sformatf("v%0d_redir", i),
                out_redirect_pc, v[i].eredir);
            chk($sformatf("v%0d_bcnt", i),
                branch_cnt, exp_bc);
            chk($sformatf("v%0d_mcnt", i),
                mispred_cnt, exp_mc);
        end

        in_valid = 1'b0;
        step();
        chk("drain_valid", {31'b0, out_valid}, 0);
        chk("drain_hold", out_target, 32'h910);

        drive(OP_BEQ, OP_TYPE_BJ, 32'h1000, 0, 0,
              32'h10, 1'b1, 32'h1010);
        in_valid = 1'b1;
        step();
        exp_bc++;
        chk("hsA_target", out_target, 32'h1010);
        drive(OP_BNE, OP_TYPE_BJ, 32'h1100, 1, 2,
              32'h20, 1'b0, 32'h0);
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", {31'b0, in_ready}, 0);
        step();
        chk("stall_valid", {31'b0, out_valid}, 1);
        chk("stall_target", out_target, 32'h1010);
        chk("stall_bcnt", branch_cnt, exp_bc);
        out_ready = 1'b1;
        #1;
        chk("go_in_ready", {31'b0, in_ready}, 1);
        step();
        exp_bc++;
        exp_mc++;
        chk("b2b_valid", {31'b0, out_valid}, 1);
        chk("b2b_target", out_target, 32'h1120);
        chk("b2b_mis", {31'b0, out_mispredict}, 1);
        chk("b2b_bcnt", branch_cnt, exp_bc);

        drive(OP_B, OP_TYPE_BJ, 32'h1200, 0, 0,
              32'h4, 1'b0, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 0);
        step();
        chk("flush_valid", {31'b0, out_valid}, 0);
        chk("flush_bcnt", branch_cnt, exp_bc);
        chk("flush_mcnt", mispred_cnt, exp_mc);
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        chk("post_flush_valid", {31'b0, out_valid}, 0);
        chk("post_flush_hold", out_target, 32'h1120);

        lk_pc = 32'h40;
        #1;
        chk("bht_init", {31'b0, lk_taken}, 0);
        for (int i = 0; i < 3; i++) begin
            drive(OP_BNE, OP_TYPE_BJ, 32'h40, 1, 2,
                  32'h8, 1'b1, 32'h48);
            in_valid = 1'b1;
            step();
            exp_bc++;
            chk($sformatf("bht_up%0d", i),
                {31'b0, lk_taken}, {31'b0, BHT_ON});
        end
        for (int i = 0; i < 4; i++) begin
            drive(OP_BNE, OP_TYPE_BJ, 32'h40, 7, 7,
                  32'h8, 1'b0, 32'h0);
            in_valid = 1'b1;
            step();
            exp_bc++;
            chk($sformatf("bht_dn%0d", i),
                {31'b0, lk_taken},
                {31'b0, BHT_ON && (i == 0)});
        end
        chk("bht_bcnt", branch_cnt, exp_bc);
        chk("bht_mcnt", mispred_cnt, exp_mc);

        in_valid = 1'b0;
        step();
        force dut.branch_cnt = 32'hFFFFFFFE;
        #1;
        release dut.branch_cnt;
        exp_bc = 32'hFFFFFFFE;
        for (int i = 0; i < 3; i++) begin
            drive(OP_B, OP_TYPE_BJ, 32'h2000, 0, 0,
                  32'h0, 1'b1, 32'h2000);
            in_valid = 1'b1;
            step();
            exp_bc++;
            chk($sformatf("wrap%0d", i),
                branch_cnt, exp_bc);
        end
        chk("wrap_final", branch_cnt, 32'h1);
        chk("wrap_mcnt", mispred_cnt, exp_mc);
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
